// File: rtl/ibex_rvfi_trace_fifo.sv
// Captures one compact record per RVFI retirement into a circular buffer and streams it out via valid/ready.
// Also keeps a saturating count of records lost to overflow and a sticky rvfi_order discontinuity flag.
module ibex_rvfi_trace_fifo #(
  parameter int unsigned Depth        = 8,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       rvfi_valid,
  input  logic [63:0]                rvfi_order,
  input  logic [31:0]                rvfi_insn,
  input  logic                       rvfi_trap,
  input  logic                       rvfi_intr,
  input  logic [31:0]                rvfi_pc_rdata,
  input  logic [4:0]                 rvfi_rd_addr,
  input  logic [31:0]                rvfi_rd_wdata,
  input  logic [31:0]                rvfi_mem_addr,
  input  logic [3:0]                 rvfi_mem_rmask,
  input  logic [3:0]                 rvfi_mem_wmask,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [31:0]                trace_pc_o,
  output logic [31:0]                trace_insn_o,
  output logic [31:0]                trace_rd_wdata_o,
  output logic [31:0]                trace_mem_addr_o,
  output logic [4:0]                 trace_rd_addr_o,
  output logic [7:0]                 trace_mem_mask_o,
  output logic [1:0]                 trace_flags_o,
  output logic [15:0]                trace_seq_o,
  output logic [$clog2(Depth):0]     level_o,
  output logic [DropCntWidth-1:0]    drop_cnt_o,
  output logic                       order_err_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [15:0] seq;
    logic [1:0]  flags;
    logic [7:0]  mask;
    logic [4:0]  rd_addr;
    logic [31:0] mem_addr;
    logic [31:0] rd_wdata;
    logic [31:0] insn;
    logic [31:0] pc;
  } rec_t;

  rec_t                    mem_q [Depth];
  rec_t                    wr_rec, rd_rec;
  logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  // The count needs one extra bit so that a full buffer is distinguishable from an empty one.
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DropCntWidth-1:0] drop_q, drop_d;
  logic                    err_q, err_d;
  logic [63:0]             last_q, last_d;
  logic                    seen_q, seen_d;
  logic                    full, push, pop, drop, order_bad;

  assign full      = (cnt_q == CW'(Depth));
  assign pop       = trace_valid_o && trace_ready_i;
  assign push      = rvfi_valid && (!full || pop);
  assign drop      = rvfi_valid && !push;
  // Checked on every retirement, dropped ones included, so losses never mask a gap.
  assign order_bad = rvfi_valid && seen_q && (rvfi_order != last_q + 64'd1);

  assign wr_rec = '{seq:      rvfi_order[15:0],
                    flags:    {rvfi_intr, rvfi_trap},
                    mask:     {rvfi_mem_wmask, rvfi_mem_rmask},
                    rd_addr:  rvfi_rd_addr,
                    mem_addr: rvfi_mem_addr,
                    rd_wdata: rvfi_rd_wdata,
                    insn:     rvfi_insn,
                    pc:       rvfi_pc_rdata};

  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // A same-cycle event beats clear so that nothing is silently lost.
    if (clear_i) begin
      drop_d = {{(DropCntWidth-1){1'b0}}, drop};
      err_d  = order_bad;
    end else begin
      drop_d = (drop && !(&drop_q)) ? drop_q + DropCntWidth'(1) : drop_q;
      err_d  = err_q | order_bad;
    end
    last_d = rvfi_valid ? rvfi_order : last_q;
    seen_d = seen_q | rvfi_valid;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
      err_q  <= 1'b0;
      last_q <= '0;
      seen_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      err_q  <= err_d;
      last_q <= last_d;
      seen_q <= seen_d;
    end
  end

  // Only entry 0 is cleared: it is the head after reset, so the outputs read zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= wr_rec;
    end
  end

  assign rd_rec           = mem_q[rptr_q];
  assign trace_valid_o    = (cnt_q != '0);
  assign trace_pc_o       = rd_rec.pc;
  assign trace_insn_o     = rd_rec.insn;
  assign trace_rd_wdata_o = rd_rec.rd_wdata;
  assign trace_mem_addr_o = rd_rec.mem_addr;
  assign trace_rd_addr_o  = rd_rec.rd_addr;
  assign trace_mem_mask_o = rd_rec.mask;
  assign trace_flags_o    = rd_rec.flags;
  assign trace_seq_o      = rd_rec.seq;
  assign level_o          = cnt_q;
  assign drop_cnt_o       = drop_q;
  assign order_err_o      = err_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_fifo.sv
// Bench for ibex_rvfi_trace_fifo: constant vector table, corner-case sequences, then random traffic against a queue model.
module tb_ibex_rvfi_trace_fifo;

  localparam int DEPTH = 8;
  localparam int DCW   = 12;
  localparam logic [DCW-1:0] DMAX = {DCW{1'b1}};

  logic        clk = 1'b0;
  logic        rst_n, clear, rvfi_valid, rvfi_trap, rvfi_intr, trace_ready;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_rd_wdata, rvfi_mem_addr;
  logic [4:0]  rvfi_rd_addr;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  logic        trace_valid;
  logic [31:0] trace_pc, trace_insn, trace_rd_wdata, trace_mem_addr;
  logic [4:0]  trace_rd_addr;
  logic [7:0]  trace_mem_mask;
  logic [1:0]  trace_flags;
  logic [15:0] trace_seq;
  logic [3:0]  level;
  logic [DCW-1:0] drop_cnt;
  logic        order_err;

  always #5 clk = ~clk;

  ibex_rvfi_trace_fifo #(.Depth(DEPTH), .DropCntWidth(DCW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .trace_valid_o(trace_valid), .trace_ready_i(trace_ready),
    .trace_pc_o(trace_pc), .trace_insn_o(trace_insn), .trace_rd_wdata_o(trace_rd_wdata),
    .trace_mem_addr_o(trace_mem_addr), .trace_rd_addr_o(trace_rd_addr),
    .trace_mem_mask_o(trace_mem_mask), .trace_flags_o(trace_flags), .trace_seq_o(trace_seq),
    .level_o(level), .drop_cnt_o(drop_cnt), .order_err_o(order_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: an ordered queue of expected output records plus plain counters.
  logic [158:0] mq[$];
  int           m_drop;
  bit           m_err, m_seen;
  logic [63:0]  m_last;

  function automatic logic [158:0] cur_rec();
    return {rvfi_order[15:0], rvfi_intr, rvfi_trap, rvfi_mem_wmask, rvfi_mem_rmask,
            rvfi_rd_addr, rvfi_mem_addr, rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata};
  endfunction

  task automatic do_cycle();
    bit pop, drop, bad;
    if (!rst_n) begin
      mq.delete(); m_drop = 0; m_err = 0; m_seen = 0; m_last = '0;
    end else begin
      pop  = (mq.size() > 0) && trace_ready;
      drop = rvfi_valid && (mq.size() == DEPTH) && !pop;
      bad  = rvfi_valid && m_seen && (rvfi_order != m_last + 64'd1);
      if (pop) void'(mq.pop_front());
      if (rvfi_valid && !drop) mq.push_back(cur_rec());
      if (rvfi_valid) begin m_last = rvfi_order; m_seen = 1; end
      if (clear) m_drop = drop ? 1 : 0;
      else if (drop && m_drop < int'(DMAX)) m_drop++;
      m_err = clear ? bad : (m_err | bad);
    end
    @(posedge clk); #1;
    check("level", level, mq.size());
    check("valid", trace_valid, mq.size() != 0);
    check("drop_cnt", drop_cnt, m_drop);
    check("order_err", order_err, m_err);
    if (mq.size() != 0)
      check("head", {trace_seq, trace_flags, trace_mem_mask, trace_rd_addr, trace_mem_addr,
                     trace_rd_wdata, trace_insn, trace_pc}, mq[0]);
  endtask

  task automatic set_rec(input logic [63:0] ord, input logic [31:0] pc);
    rvfi_order = ord; rvfi_pc_rdata = pc; rvfi_insn = ~pc; rvfi_rd_wdata = pc + 32'h11;
    rvfi_mem_addr = {pc[15:0], pc[31:16]}; rvfi_rd_addr = pc[6:2];
    rvfi_mem_rmask = pc[3:0]; rvfi_mem_wmask = pc[7:4]; rvfi_trap = pc[2]; rvfi_intr = pc[3];
  endtask

  task automatic cyc(input bit r, input bit c, input bit v, input logic [63:0] o,
                     input logic [31:0] p, input bit rdy);
    rst_n = r; clear = c; rvfi_valid = v; trace_ready = rdy;
    set_rec(o, p);
    do_cycle();
  endtask

  typedef struct {
    bit r, c, v; logic [63:0] o; logic [31:0] p; bit rdy;
    int lvl; bit tv; logic [31:0] hpc; int drp; bit err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, c, v, input logic [63:0] o, input logic [31:0] p, input bit rdy,
                     input int lvl, input bit tv, input logic [31:0] hpc, input int drp, input bit err);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.o = o; t.p = p; t.rdy = rdy;
    t.lvl = lvl; t.tv = tv; t.hpc = hpc; t.drp = drp; t.err = err;
    tbl.push_back(t);
  endtask

  initial begin
    logic [63:0] nord;
    // Order discontinuity 5,6,8 then clear then 9.
    add(0,0,0, 0, 0,      1, 0,0,0,      0,0);
    add(1,0,1, 5, 'h500,  1, 1,1,'h500,  0,0);
    add(1,0,1, 6, 'h504,  1, 1,1,'h504,  0,0);
    add(1,0,1, 8, 'h508,  1, 1,1,'h508,  0,1);
    add(1,1,0, 0, 0,      1, 0,0,0,      0,0);
    add(1,0,1, 9, 'h50C,  1, 1,1,'h50C,  0,0);
    add(1,0,0, 0, 0,      1, 0,0,0,      0,0);
    // Streaming with ready high.
    add(0,0,0, 0, 0,      1, 0,0,0,      0,0);
    add(1,0,1, 0, 'h100,  1, 1,1,'h100,  0,0);
    add(1,0,1, 1, 'h104,  1, 1,1,'h104,  0,0);
    add(1,0,1, 2, 'h108,  1, 1,1,'h108,  0,0);
    add(1,0,0, 0, 0,      1, 0,0,0,      0,0);
    // Overflow with ready low: ten records into eight entries.
    for (int i = 0; i < 10; i++)
      add(1,0,1, 3+i, 'h200+4*i, 0, (i < 8) ? i+1 : 8, 1, 'h200, (i < 8) ? 0 : i-7, 0);
    // Push and pop together at full.
    add(1,0,1, 13, 'h300, 1, 8,1,'h204, 2,0);
    for (int j = 1; j <= 8; j++)
      add(1,0,0, 0, 0, 1, 8-j, j < 8, (j < 7) ? 'h204+4*j : 'h300, 2, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].r, tbl[k].c, tbl[k].v, tbl[k].o, tbl[k].p, tbl[k].rdy);
      check($sformatf("vec%0d_level", k), level, tbl[k].lvl);
      check($sformatf("vec%0d_valid", k), trace_valid, tbl[k].tv);
      check($sformatf("vec%0d_drop", k), drop_cnt, tbl[k].drp);
      check($sformatf("vec%0d_err", k), order_err, tbl[k].err);
      if (tbl[k].tv) check($sformatf("vec%0d_pc", k), trace_pc, tbl[k].hpc);
    end

    // Reset with four records queued, while a push and a ready are presented.
    cyc(0,0,0, 0, 0, 0);
    check("rst_pc_zero", trace_pc, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1,0,1, i, 'h800+4*i, 0);
    check("queued4", level, 4);
    cyc(0,0,1, 4, 'h810, 1);
    check("midrst_valid", trace_valid, 1'b0);
    check("midrst_level", level, 0);
    check("midrst_pc", trace_pc, 32'h0);
    check("midrst_insn", trace_insn, 32'h0);
    check("midrst_wdata", trace_rd_wdata, 32'h0);
    cyc(1,0,1, 100, 'h900, 0);
    check("after_rst_valid", trace_valid, 1'b1);
    check("after_rst_pc", trace_pc, 32'h900);

    // Saturate the drop counter.
    nord = 101;
    for (int i = 0; i < DEPTH - 1 + int'(DMAX) + 5; i++) begin
      cyc(1,0,1, nord, 'hA00 + 4*i, 0);
      nord++;
    end
    check("sat_drop", drop_cnt, DMAX);
    check("sat_level", level, DEPTH);
    cyc(1,1,1, nord, 'hB00, 0);
    nord++;
    check("clear_with_drop", drop_cnt, 1);
    cyc(1,1,1, nord + 7, 'hB04, 0);
    check("clear_with_err", order_err, 1'b1);
    cyc(1,1,0, 0, 0, 1);
    check("clear_only_err", order_err, 1'b0);
    check("clear_only_drop", drop_cnt, 0);

    // Random traffic, starting near the 64-bit order wrap.
    nord = 64'hFFFF_FFFF_FFFF_FFF0;
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      clear       = ($urandom_range(0, 39) == 0);
      rvfi_valid  = ($urandom_range(0, 9) < 7);
      trace_ready = ($urandom_range(0, 3) < (((i / 400) % 2 == 0) ? 1 : 3));
      if ($urandom_range(0, 24) == 0) nord = {$urandom, $urandom};
      rvfi_order     = nord;
      rvfi_insn      = $urandom;
      rvfi_pc_rdata  = $urandom;
      rvfi_rd_wdata  = $urandom;
      rvfi_mem_addr  = $urandom;
      rvfi_rd_addr   = 5'($urandom);
      rvfi_mem_rmask = 4'($urandom);
      rvfi_mem_wmask = 4'($urandom);
      rvfi_trap      = 1'($urandom);
      rvfi_intr      = 1'($urandom);
      if (rvfi_valid) nord = nord + 64'd1;
      do_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
